// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and encodings for the pipeline sequencer.
// Imported by the forwarding unit and the top-level controller.
package pipeline_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [31:0] HALT_CODE_DEF = 32'd10;

endpackage

// File: rtl/forwarding_unit.sv
// EX-stage operand source selection from the EX/MEM and MEM/WB
// writeback ports; the younger EX/MEM result always wins.
module forwarding_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       mem_regwrite,
    input  logic [4:0] mem_write_reg,
    input  logic       wb_regwrite,
    input  logic [4:0] wb_write_reg,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    function automatic logic [1:0] pick(
        input logic [4:0] src,
        input logic       m_we,
        input logic [4:0] m_rd,
        input logic       w_we,
        input logic [4:0] w_rd
    );
        if (m_we && m_rd != 5'd0 && m_rd == src)
            return FWD_EXMEM;
        else if (w_we && w_rd != 5'd0 && w_rd == src)
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        fwd_a = pick(rs, mem_regwrite, mem_write_reg,
                     wb_regwrite, wb_write_reg);
        fwd_b = pick(rt, mem_regwrite, mem_write_reg,
                     wb_regwrite, wb_write_reg);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer of the five-stage pipeline: hazard priority,
// run/halt FSM, resume-button edge detect and performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] HALT_CODE = HALT_CODE_DEF,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_r1_used,
    input  logic             id_r2_used,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             ex_memtoreg,
    input  logic             ex_regwrite,
    input  logic [4:0]       ex_write_reg,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_write_reg,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_write_reg,
    input  logic             ex_redirect,
    input  logic             wb_syscall,
    input  logic [31:0]      wb_v0,
    input  logic             go,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_clr,
    output logic             idex_clr,
    output logic             exmem_clr,
    output logic             memwb_clr,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t     state;
    state_t     state_nxt;
    logic       go_q;
    logic       go_rise;
    logic       load_use;
    logic       halt_hit;
    logic       row_busy;
    logic       row_halt;
    logic       row_redir;
    logic       row_lu;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    assign go_rise = go & ~go_q;

    assign load_use = ex_memtoreg & ex_regwrite
                    & (ex_write_reg != 5'd0)
                    & ((id_r1_used & (ex_write_reg == id_rs))
                     | (id_r2_used & (ex_write_reg == id_rt)));

    assign halt_hit = wb_syscall & (wb_v0 == HALT_CODE);

    // Strict priority: memory freeze, halt, redirect, load-use.
    assign row_busy  = mem_busy;
    assign row_halt  = ~mem_busy & halt_hit;
    assign row_redir = ~mem_busy & ~halt_hit & ex_redirect;
    assign row_lu    = ~mem_busy & ~halt_hit & ~ex_redirect & load_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (row_halt) state_nxt = HALT;
            HALT:    if (go_rise)  state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        idex_en   = 1'b0;
        exmem_en  = 1'b0;
        memwb_en  = 1'b0;
        ifid_clr  = 1'b0;
        idex_clr  = 1'b0;
        memwb_clr = 1'b0;
        if (rst_n && state == RUN) begin
            if (row_busy) begin
                pc_en = 1'b0;
            end else if (row_halt) begin
                memwb_en  = 1'b1;
                memwb_clr = 1'b1;
            end else if (row_redir) begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
                ifid_clr = 1'b1;
                idex_clr = 1'b1;
            end else if (row_lu) begin
                idex_en  = 1'b1;
                idex_clr = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        end
    end

    assign exmem_clr = 1'b0;
    assign halted    = (state == HALT);

    // Reset value of 1 keeps a button held through reset from resuming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go_q <= 1'b1;
        end else begin
            go_q <= go;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state == RUN) begin
            cycle_cnt <= cycle_cnt + ONE;
            if (row_busy || row_lu) begin
                stall_cnt <= stall_cnt + ONE;
            end
            if (row_redir) begin
                flush_cnt <= flush_cnt + ONE;
            end
        end
    end

    forwarding_unit u_fwd (
        .rs            (ex_rs),
        .rt            (ex_rt),
        .mem_regwrite  (mem_regwrite),
        .mem_write_reg (mem_write_reg),
        .wb_regwrite   (wb_regwrite),
        .wb_write_reg  (wb_write_reg),
        .fwd_a         (fwd_a_raw),
        .fwd_b         (fwd_b_raw)
    );

    assign fwd_a = rst_n ? fwd_a_raw : FWD_RF;
    assign fwd_b = rst_n ? fwd_b_raw : FWD_RF;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl with 4-bit counters.
// Inputs change just after rising edges; outputs sampled 2ns later.
module tb_pipeline_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs, id_rt;
    logic             id_r1_used, id_r2_used;
    logic [4:0]       ex_rs, ex_rt;
    logic             ex_memtoreg, ex_regwrite;
    logic [4:0]       ex_write_reg;
    logic             mem_regwrite;
    logic [4:0]       mem_write_reg;
    logic             wb_regwrite;
    logic [4:0]       wb_write_reg;
    logic             ex_redirect, wb_syscall;
    logic [31:0]      wb_v0;
    logic             go, mem_busy;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_clr, idex_clr, exmem_clr, memwb_clr;
    logic [1:0]       fwd_a, fwd_b;
    logic             halted;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;

    logic [4:0] en;
    logic [3:0] clr;
    assign en  = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    assign clr = {ifid_clr, idex_clr, exmem_clr, memwb_clr};

    logic [CNT_W-1:0] exp_cycle, exp_stall, exp_flush;
    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.HALT_CODE(32'd10), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_r1_used(id_r1_used), .id_r2_used(id_r2_used),
        .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
        .ex_write_reg(ex_write_reg),
        .mem_regwrite(mem_regwrite), .mem_write_reg(mem_write_reg),
        .wb_regwrite(wb_regwrite), .wb_write_reg(wb_write_reg),
        .ex_redirect(ex_redirect), .wb_syscall(wb_syscall),
        .wb_v0(wb_v0), .go(go), .mem_busy(mem_busy),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_clr(ifid_clr), .idex_clr(idex_clr),
        .exmem_clr(exmem_clr), .memwb_clr(memwb_clr),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    task automatic idle();
        id_rs = 0; id_rt = 0; id_r1_used = 0; id_r2_used = 0;
        ex_rs = 0; ex_rt = 0; ex_memtoreg = 0; ex_regwrite = 0;
        ex_write_reg = 0; mem_regwrite = 0; mem_write_reg = 0;
        wb_regwrite = 0; wb_write_reg = 0; ex_redirect = 0;
        wb_syscall = 0; wb_v0 = 0; mem_busy = 0;
    endtask

    task automatic set_load_use();
        ex_memtoreg = 1; ex_regwrite = 1; ex_write_reg = 8;
        id_rs = 8; id_r1_used = 1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Advance one rising edge; the caller states which counters move.
    task automatic tick(input bit run, input bit stall, input bit flush);
        @(posedge clk);
        #1;
        if (run)   exp_cycle = exp_cycle + 1'b1;
        if (stall) exp_stall = exp_stall + 1'b1;
        if (flush) exp_flush = exp_flush + 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0; go = 1;
        ex_rs = 5; mem_regwrite = 1; mem_write_reg = 5;
        #12;
        checks++;
        if (en !== 5'b0 || clr !== 4'b0) begin
            fails++;
            $display("FAIL rst_ctrl: got en=%b clr=%b want 0/0", en, clr);
        end
        checks++;
        if (fwd_a !== 2'b00 || halted !== 1'b0) begin
            fails++;
            $display("FAIL rst_fwd: got fwd_a=%b halted=%b want 00/0",
                     fwd_a, halted);
        end
        checks++;
        if (cycle_cnt !== 4'd0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            fails++;
            $display("FAIL rst_cnt: got %0d/%0d/%0d want 0/0/0",
                     cycle_cnt, stall_cnt, flush_cnt);
        end
        exp_cycle = 0; exp_stall = 0; exp_flush = 0;
        @(posedge clk);
        #1;
        idle();
        rst_n = 1; go = 0;
        settle();
        checks++;
        if (en !== 5'b11111 || clr !== 4'b0000) begin
            fails++;
            $display("FAIL run_default: got en=%b clr=%b want 11111/0000",
                     en, clr);
        end
        tick(1, 0, 0);
        checks++;
        if (cycle_cnt !== exp_cycle) begin
            fails++;
            $display("FAIL cycle_first: got %0d want %0d", cycle_cnt, exp_cycle);
        end
    endtask

    task automatic test_load_use();
        idle();
        set_load_use();
        settle();
        checks++;
        if (pc_en !== 0 || ifid_en !== 0 || idex_clr !== 1 || memwb_en !== 1
            || exmem_en !== 1) begin
            fails++;
            $display("FAIL lu_rs: got en=%b clr=%b want pc/ifid 0, idex_clr 1",
                     en, clr);
        end
        tick(1, 1, 0);
        checks++;
        if (stall_cnt !== exp_stall) begin
            fails++;
            $display("FAIL lu_stall_cnt: got %0d want %0d", stall_cnt, exp_stall);
        end
        id_r1_used = 0;
        settle();
        checks++;
        if (en !== 5'b11111 || clr !== 4'b0000) begin
            fails++;
            $display("FAIL lu_unused: got en=%b clr=%b want 11111/0000", en, clr);
        end
        tick(1, 0, 0);
        id_rs = 0; id_rt = 8; id_r2_used = 1;
        settle();
        checks++;
        if (pc_en !== 0 || idex_clr !== 1) begin
            fails++;
            $display("FAIL lu_rt: got pc_en=%b idex_clr=%b want 0/1",
                     pc_en, idex_clr);
        end
        tick(1, 1, 0);
        ex_write_reg = 0; id_rt = 0;
        settle();
        checks++;
        if (pc_en !== 1 || idex_clr !== 0) begin
            fails++;
            $display("FAIL lu_r0: got pc_en=%b idex_clr=%b want 1/0",
                     pc_en, idex_clr);
        end
        tick(1, 0, 0);
        checks++;
        if (stall_cnt !== exp_stall || cycle_cnt !== exp_cycle) begin
            fails++;
            $display("FAIL lu_cnts: got %0d/%0d want %0d/%0d",
                     stall_cnt, cycle_cnt, exp_stall, exp_cycle);
        end
    endtask

    task automatic test_redirect();
        idle();
        set_load_use();
        ex_redirect = 1;
        settle();
        checks++;
        if (en !== 5'b11111 || clr !== 4'b1100) begin
            fails++;
            $display("FAIL redir: got en=%b clr=%b want 11111/1100", en, clr);
        end
        tick(1, 0, 1);
        checks++;
        if (flush_cnt !== exp_flush || stall_cnt !== exp_stall) begin
            fails++;
            $display("FAIL redir_cnt: got flush=%0d stall=%0d want %0d/%0d",
                     flush_cnt, stall_cnt, exp_flush, exp_stall);
        end
    endtask

    task automatic test_forwarding();
        idle();
        ex_rs = 5; ex_rt = 7;
        mem_regwrite = 1; mem_write_reg = 5;
        wb_regwrite = 1; wb_write_reg = 5;
        settle();
        checks++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
            fails++;
            $display("FAIL fwd_exmem: got a=%b b=%b want 01/00", fwd_a, fwd_b);
        end
        tick(1, 0, 0);
        mem_regwrite = 0; ex_rt = 5;
        settle();
        checks++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
            fails++;
            $display("FAIL fwd_memwb: got a=%b b=%b want 10/10", fwd_a, fwd_b);
        end
        tick(1, 0, 0);
        mem_regwrite = 1; mem_write_reg = 7; ex_rt = 7; wb_write_reg = 9;
        settle();
        checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b01) begin
            fails++;
            $display("FAIL fwd_mixed: got a=%b b=%b want 00/01", fwd_a, fwd_b);
        end
        tick(1, 0, 0);
        ex_rs = 0; ex_rt = 0; mem_write_reg = 0; wb_write_reg = 0;
        settle();
        checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            fails++;
            $display("FAIL fwd_r0: got a=%b b=%b want 00/00", fwd_a, fwd_b);
        end
        tick(1, 0, 0);
    endtask

    task automatic test_halt();
        logic [CNT_W-1:0] snap;
        idle();
        wb_syscall = 1; wb_v0 = 4;
        settle();
        checks++;
        if (en !== 5'b11111 || memwb_clr !== 0) begin
            fails++;
            $display("FAIL nohalt_v0_4: got en=%b memwb_clr=%b want 11111/0",
                     en, memwb_clr);
        end
        tick(1, 0, 0);
        go = 1;
        wb_v0 = 10;
        settle();
        checks++;
        if (en !== 5'b00001 || clr !== 4'b0001 || halted !== 0) begin
            fails++;
            $display("FAIL halt_hit: got en=%b clr=%b halted=%b want 00001/0001/0",
                     en, clr, halted);
        end
        tick(1, 0, 0);
        idle();
        settle();
        checks++;
        if (halted !== 1 || en !== 5'b0 || clr !== 4'b0) begin
            fails++;
            $display("FAIL halt_state: got halted=%b en=%b clr=%b want 1/0/0",
                     halted, en, clr);
        end
        snap = exp_cycle;
        tick(0, 0, 0);
        tick(0, 0, 0);
        checks++;
        if (halted !== 1 || cycle_cnt !== snap) begin
            fails++;
            $display("FAIL halt_held_go: got halted=%b cycle=%0d want 1/%0d",
                     halted, cycle_cnt, snap);
        end
        go = 0;
        tick(0, 0, 0);
        go = 1;
        settle();
        checks++;
        if (halted !== 1) begin
            fails++;
            $display("FAIL halt_rise_cycle: got halted=%b want 1", halted);
        end
        tick(0, 0, 0);
        go = 0;
        settle();
        checks++;
        if (halted !== 0 || en !== 5'b11111) begin
            fails++;
            $display("FAIL resume: got halted=%b en=%b want 0/11111", halted, en);
        end
        tick(1, 0, 0);
        checks++;
        if (cycle_cnt !== exp_cycle || stall_cnt !== exp_stall) begin
            fails++;
            $display("FAIL halt_cnts: got %0d/%0d want %0d/%0d",
                     cycle_cnt, stall_cnt, exp_cycle, exp_stall);
        end
    endtask

    task automatic test_busy();
        idle();
        set_load_use();
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (en !== 5'b0 || clr !== 4'b0) begin
                fails++;
                $display("FAIL busy_%0d: got en=%b clr=%b want 0/0", i, en, clr);
            end
            tick(1, 1, 0);
        end
        checks++;
        if (stall_cnt !== exp_stall) begin
            fails++;
            $display("FAIL busy_stall_cnt: got %0d want %0d", stall_cnt, exp_stall);
        end
        mem_busy = 0;
        settle();
        checks++;
        if (en !== 5'b00111 || clr !== 4'b0100) begin
            fails++;
            $display("FAIL busy_then_lu: got en=%b clr=%b want 00111/0100", en, clr);
        end
        tick(1, 1, 0);
        idle();
        wb_syscall = 1; wb_v0 = 10; mem_busy = 1;
        settle();
        checks++;
        if (en !== 5'b0 || memwb_clr !== 0) begin
            fails++;
            $display("FAIL busy_over_halt: got en=%b memwb_clr=%b want 0/0",
                     en, memwb_clr);
        end
        tick(1, 1, 0);
        checks++;
        if (halted !== 0) begin
            fails++;
            $display("FAIL busy_no_halt: got halted=%b want 0", halted);
        end
        mem_busy = 0;
        tick(1, 0, 0);
        idle();
        checks++;
        if (halted !== 1 || stall_cnt !== exp_stall) begin
            fails++;
            $display("FAIL halt_after_busy: got halted=%b stall=%0d want 1/%0d",
                     halted, stall_cnt, exp_stall);
        end
        go = 1;
        tick(0, 0, 0);
        go = 0;
        checks++;
        if (halted !== 0) begin
            fails++;
            $display("FAIL resume2: got halted=%b want 0", halted);
        end
    endtask

    task automatic test_wrap();
        idle();
        while (exp_cycle != 4'd15) tick(1, 0, 0);
        checks++;
        if (cycle_cnt !== 4'd15) begin
            fails++;
            $display("FAIL wrap_pre: got %0d want 15", cycle_cnt);
        end
        tick(1, 0, 0);
        checks++;
        if (cycle_cnt !== 4'd0) begin
            fails++;
            $display("FAIL wrap: got %0d want 0", cycle_cnt);
        end
    endtask

    task automatic test_reset_mid_halt();
        idle();
        wb_syscall = 1; wb_v0 = 10;
        tick(1, 0, 0);
        idle();
        checks++;
        if (halted !== 1) begin
            fails++;
            $display("FAIL pre_reset_halt: got halted=%b want 1", halted);
        end
        rst_n = 0;
        #1;
        checks++;
        if (halted !== 0 || en !== 5'b0 || cycle_cnt !== 4'd0
            || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            fails++;
            $display("FAIL mid_halt_reset: got halted=%b en=%b cnt=%0d/%0d/%0d",
                     halted, en, cycle_cnt, stall_cnt, flush_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        settle();
        checks++;
        if (halted !== 0 || en !== 5'b11111) begin
            fails++;
            $display("FAIL post_reset_run: got halted=%b en=%b want 0/11111",
                     halted, en);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_forwarding();
        test_halt();
        test_busy();
        test_wrap();
        test_reset_mid_halt();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencer for the five-stage MIPS pipeline. It drives the enable and synchronous-clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register. It detects load-use hazards, flushes on control redirects resolved in EX, freezes the pipe while memory is busy, and halts on the terminating syscall. It also generates the EX-stage forwarding selects and keeps performance counters for the board display.

## Interface
Parameters:
- HALT_CODE, 10, value of $v0 at a WB-stage syscall that halts the CPU
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  5  source register numbers of the instruction in ID
- id_r1_used, id_r2_used  in  1  ID instruction actually reads rs / rt
- ex_rs, ex_rt  in  5  source register numbers in ID/EX (for forwarding)
- ex_memtoreg, ex_regwrite  in  1  ID/EX instruction is a load / writes a register
- ex_write_reg  in  5  ID/EX destination register
- mem_regwrite  in  1, mem_write_reg  in  5  EX/MEM writeback info
- wb_regwrite  in  1, wb_write_reg  in  5  MEM/WB writeback info
- ex_redirect  in  1  taken branch, jump, jr or jal resolved in EX this cycle
- wb_syscall  in  1  MEM/WB holds a syscall
- wb_v0  in  32  current $v0 value seen by WB
- go  in  1  resume button, level; only a rising edge acts
- mem_busy  in  1  data memory cannot complete this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  register enables
- ifid_clr, idex_clr, exmem_clr, memwb_clr  out  1  register synchronous clears
- fwd_a, fwd_b  out  2  EX operand source: 00 register file, 01 EX/MEM result, 10 MEM/WB result
- halted  out  1  high in HALT
- cycle_cnt, stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
- The FSM has two states: RUN and HALT. Reset enters RUN.
- A `go_q` register samples `go`. `go_rise` is defined as `go & ~go_q`.
- Register 0 never causes a hazard and never forwards.
- `load_use` is `ex_memtoreg & ex_regwrite & ex_write_reg!=0 & ((id_r1_used & ex_write_reg==id_rs) | (id_r2_used & ex_write_reg==id_rt))`.
- `halt_hit` is `wb_syscall & wb_v0==HALT_CODE`.
- RUN outputs use the first matching row (strict priority):
  - mem_busy: all five enables 0; all clears 0.
  - halt_hit: pc_en, ifid_en, idex_en and exmem_en are 0; memwb_clr is 1. The syscall commits this cycle and WB receives a bubble. The next state is HALT.
  - ex_redirect: all enables 1; ifid_clr and idex_clr are 1 (squashes two wrong-path instructions). A coincident load_use is ignored.
  - load_use: pc_en and ifid_en are 0; idex_clr is 1 (bubble); exmem_en and memwb_en are 1.
  - default: all enables 1; all clears 0.
- exmem_clr is always 0. The output is reserved.
- In HALT, all enables and clears are 0 and halted is 1. A `go_rise` moves the FSM to RUN. Execution resumes with the instruction held in EX/MEM.
- Forwarding (fwd_a from ex_rs, fwd_b from ex_rt):
  - 01 when `mem_regwrite & mem_write_reg!=0 & match`.
  - Otherwise 10 when `wb_regwrite & wb_write_reg!=0 & match`.
  - Otherwise 00.
  - EX/MEM wins over MEM/WB.
- Counters, all wrapping from 2^CNT_W-1 to 0:
  - cycle_cnt increments every RUN cycle.
  - stall_cnt increments on RUN cycles that apply the mem_busy or load_use row.
  - flush_cnt increments on RUN cycles that apply the ex_redirect row.
  - Counters hold in HALT. Only rst_n clears them.

## Timing
- While rst_n is low:
  - state = RUN, go_q = 1 (so a held button does not resume), counters = 0.
  - All enables, clears and fwd selects are 0; halted = 0.
- Enables, clears and fwd selects are combinational from the registered state and current-cycle inputs, so they are valid in the same cycle.
- halted is registered: it rises on the edge after halt_hit and falls on the edge after go_rise.
- If halt_hit and mem_busy coincide, mem_busy wins. Halt is taken in the first cycle mem_busy is low.
- Reset asserted mid-stall or mid-halt aborts immediately to the reset values above. There is no drain.

## Structure
- Package `pipeline_ctrl_pkg` holds:
  - the state enum (RUN, HALT);
  - fwd encodings FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10;
  - the default HALT_CODE.
- Sub-module `forwarding_unit` is purely combinational: rs, rt, mem/wb writeback info in; fwd_a and fwd_b out. It is instantiated once.
- Hazard priority, FSM, go edge detection and counters stay in `pipeline_ctrl`.

## Test plan
- Load-use:
  - Stimulus: ex_memtoreg=1, ex_regwrite=1, ex_write_reg=8, id_rs=8, id_r1_used=1.
  - Required: pc_en=0, ifid_en=0, idex_clr=1, memwb_en=1; stall_cnt +1.
  - Repeat with id_r1_used=0: no stall.
- Redirect with coincident load_use:
  - Required: all enables 1, ifid_clr=1, idex_clr=1; flush_cnt +1; stall_cnt unchanged.
- Forwarding:
  - mem_write_reg=wb_write_reg=5, both regwrite=1, ex_rs=5 gives fwd_a=01.
  - Dropping mem_regwrite gives fwd_a=10.
  - Register 0 always gives 00.
- Halt and resume:
  - Stimulus: wb_syscall=1, wb_v0=10.
  - Required: memwb_clr=1 that cycle; halted=1 next cycle with all enables 0 and counters frozen.
  - Holding go high does nothing. Releasing go and then pressing it returns the FSM to RUN one cycle after the rising edge.
  - wb_v0=4 with wb_syscall=1 gives no halt.
- mem_busy high for 3 cycles during load_use:
  - Required: all enables 0 and stall_cnt +3.
  - Afterwards the load_use stall applies for 1 cycle.
- Counter wrap and reset:
  - With CNT_W=4, cycle_cnt wraps 15 to 0.
  - Asserting rst_n low mid-HALT immediately gives halted=0 and counters=0.
